// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the elastic valid/ready pipeline.
//
// Handshake convention used by every stage and by the pipeline boundary:
//   - A beat moves across an interface on a rising clk edge where both
//     valid and ready are high.
//   - A producer that raises valid keeps valid and data unchanged until the
//     beat is taken (ready high at an edge).
//   - ready is allowed to depend combinationally on downstream ready, but
//     never on the valid of the same interface, so no combinational loop
//     forms between producer and consumer.
//
// Contents:
//   DEFAULT_DATA_WIDTH / DEFAULT_STAGES : default parameter values
//   cnt_width(stages)                   : bits needed to count 0..stages
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_STAGES     = 4;

    // Occupancy must represent every value from 0 up to and including the
    // stage count, hence stages+1 distinct values.
    function automatic int cnt_width(input int stages);
        if (stages < 1) begin
            return 1;
        end
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipeline_elastic_stage.sv
// ---------------------------------------------------------------------------
// pipeline_stage
// One register slice of the elastic pipeline. The slice accepts a new beat
// whenever it is empty or its current beat is leaving this cycle, so an
// empty slice keeps filling even while everything downstream is stalled.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset (clears valid and data)
//   flush     in   synchronous clear of valid only (data is kept)
//   in_data   in   payload from the previous slice / upstream
//   in_valid  in   valid from the previous slice / upstream
//   in_ready  out  this slice can take a beat this cycle
//   out_data  out  registered payload
//   out_valid out  registered valid
//   out_ready in   next slice / downstream can take our beat
// ---------------------------------------------------------------------------
module pipeline_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // Empty, or our beat is being taken this cycle: either way the register
    // is free to load at the coming edge.
    assign in_ready = out_ready | ~valid_q;

    // Reset wins over flush, flush wins over the normal load. Data is only
    // written when a real beat arrives so a bubble never disturbs the
    // payload register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/pipeline_elastic.sv
// ---------------------------------------------------------------------------
// pipeline_elastic
// Parametrised STAGES-deep valid/ready pipeline with per-stage ready, so
// bubbles collapse while downstream is stalled. Adds a synchronous flush and
// a live occupancy count. The d_ready -> u_ready path is combinational by
// design; there is no skid buffer.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   flush      in   synchronous clear of every stage valid
//   u_data     in   upstream payload
//   u_valid    in   upstream valid
//   u_ready    out  upstream ready (low during flush and reset)
//   d_data     out  downstream payload (last stage register)
//   d_valid    out  downstream valid (last stage valid)
//   d_ready    in   downstream ready
//   occupancy  out  number of stages holding a valid beat (0..STAGES)
// ---------------------------------------------------------------------------
module pipeline_elastic
    import pipeline_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int STAGES     = DEFAULT_STAGES,
    localparam int CNT_WIDTH  = cnt_width(STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] u_data,
    input  logic                  u_valid,
    output logic                  u_ready,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [CNT_WIDTH-1:0]  occupancy
);

    // Index 0 of each chain is the upstream side, index i+1 is the output of
    // stage i, so index STAGES is the downstream side.
    logic [DATA_WIDTH-1:0] chain_data [STAGES+1];
    logic [STAGES:0]       chain_valid;
    logic [STAGES:0]       chain_ready;

    assign chain_data[0]       = u_data;
    assign chain_valid[0]      = u_valid & u_ready;
    assign chain_ready[STAGES] = d_ready;

    // Masking with flush and rst_n tells the producer its beat was not taken
    // in those cycles; the stages themselves ignore input then anyway.
    assign u_ready = chain_ready[0] & ~flush & rst_n;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipeline_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_data   (chain_data[i]),
            .in_valid  (chain_valid[i]),
            .in_ready  (chain_ready[i]),
            .out_data  (chain_data[i+1]),
            .out_valid (chain_valid[i+1]),
            .out_ready (chain_ready[i+1])
        );
    end

    assign d_data  = chain_data[STAGES];
    assign d_valid = chain_valid[STAGES];

    // Popcount over the registered stage valids only; the upstream entry of
    // the chain is not storage and is excluded.
    always_comb begin
        occupancy = '0;
        for (int i = 1; i <= STAGES; i++) begin
            occupancy = occupancy + CNT_WIDTH'(chain_valid[i]);
        end
    end

endmodule

// File: tb/tb_pipeline_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipeline_elastic
// Self-checking bench for pipeline_elastic (STAGES=4, DATA_WIDTH=32).
// Accepted upstream beats are queued as expected output; a monitor pops and
// compares on every downstream transfer, and also checks occupancy against
// the queue depth and output stability while stalled. Directed sequences
// check latency, stall fill, bubble collapse, flush and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_pipeline_elastic;

    localparam int DATA_WIDTH = 32;
    localparam int STAGES     = 4;
    localparam int CNT_WIDTH  = $clog2(STAGES + 1);

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic [DATA_WIDTH-1:0] u_data;
    logic                  u_valid;
    logic                  u_ready;
    logic [DATA_WIDTH-1:0] d_data;
    logic                  d_valid;
    logic                  d_ready;
    logic [CNT_WIDTH-1:0]  occupancy;

    int checks = 0;
    int passes = 0;

    logic [DATA_WIDTH-1:0] expQ [$];

    pipeline_elastic #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .u_data    (u_data),
        .u_valid   (u_valid),
        .u_ready   (u_ready),
        .d_data    (d_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .occupancy (occupancy)
    );

    // Free-running clock, first rising edge at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point used by both the stimulus and the monitor.
    task automatic checkOutput(input string name, input logic [DATA_WIDTH-1:0] actual,
                               input logic [DATA_WIDTH-1:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the edge and let them settle.
    task automatic applyStimulus(input logic v, input logic [DATA_WIDTH-1:0] d, input logic dr);
        u_valid = v;
        u_data  = d;
        d_ready = dr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the pipe empty with downstream ready; an expired bound is a failure.
    task automatic drain(input string name);
        int n;
        n = 0;
        applyStimulus(1'b0, '0, 1'b1);
        while (occupancy != 0 && n < 50) begin
            tick();
            applyStimulus(1'b0, '0, 1'b1);
            n++;
        end
        checkOutput(name, DATA_WIDTH'(occupancy), '0);
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge where all
    // inputs and outputs are stable. Order per cycle: occupancy vs queue,
    // stability, pop on downstream transfer, push on upstream transfer, and
    // finally discard everything in flight if the coming edge flushes/resets.
    logic                  prevHold = 1'b0;
    logic [DATA_WIDTH-1:0] prevData = '0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 || expQ.size() != 0) begin
            checkOutput("occupancy_vs_scoreboard", DATA_WIDTH'(occupancy), DATA_WIDTH'(expQ.size()));
        end
        if (prevHold) begin
            checkOutput("stall_d_valid_stable", DATA_WIDTH'(d_valid), 1);
            checkOutput("stall_d_data_stable", d_data, prevData);
        end
        if (d_valid === 1'b1 && d_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", d_data, 'x);
            end else begin
                checkOutput("scoreboard_data", d_data, expQ.pop_front());
            end
        end
        if (u_valid === 1'b1 && u_ready === 1'b1) begin
            expQ.push_back(u_data);
        end
        if (rst_n !== 1'b1 || flush === 1'b1) begin
            expQ.delete();
        end
        prevHold = (d_valid === 1'b1) && (d_ready !== 1'b1) && (rst_n === 1'b1) && (flush !== 1'b1);
        prevData = d_data;
    end

    // Directed sequences followed by a random soak.
    initial begin
        int lat;

        rst_n   = 1'b0;
        flush   = 1'b0;
        u_valid = 1'b0;
        u_data  = '0;
        d_ready = 1'b0;

        // Reset state.
        tick();
        applyStimulus(1'b1, 32'h1234_5678, 1'b1);
        checkOutput("u_ready_in_reset", DATA_WIDTH'(u_ready), 0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("reset_d_valid", DATA_WIDTH'(d_valid), 0);
        checkOutput("reset_d_data", d_data, 0);
        checkOutput("reset_occupancy", DATA_WIDTH'(occupancy), 0);
        checkOutput("u_ready_after_reset", DATA_WIDTH'(u_ready), 1);

        // Latency: single beat shows on d_valid exactly STAGES cycles later.
        applyStimulus(1'b1, 32'hA5A5_A5A5, 1'b1);
        checkOutput("latency_accept", DATA_WIDTH'(u_ready), 1);
        tick();
        for (int c = 1; c <= STAGES; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("latency_occupancy", DATA_WIDTH'(occupancy), 1);
            checkOutput("latency_d_valid", DATA_WIDTH'(d_valid), (c == STAGES) ? 1 : 0);
            if (c == STAGES) begin
                checkOutput("latency_d_data", d_data, 32'hA5A5_A5A5);
            end
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("latency_gone_d_valid", DATA_WIDTH'(d_valid), 0);
        checkOutput("latency_gone_occupancy", DATA_WIDTH'(occupancy), 0);

        // Full stall: four beats fill the pipe, the fifth is held off.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, DATA_WIDTH'(k), 1'b0);
            checkOutput("stall_fill_u_ready", DATA_WIDTH'(u_ready), 1);
            tick();
        end
        applyStimulus(1'b1, 32'h5, 1'b0);
        checkOutput("stall_full_u_ready", DATA_WIDTH'(u_ready), 0);
        checkOutput("stall_full_occupancy", DATA_WIDTH'(occupancy), 4);
        checkOutput("stall_full_d_data", d_data, 32'h1);
        tick();
        applyStimulus(1'b1, 32'h5, 1'b0);
        checkOutput("stall_still_blocked", DATA_WIDTH'(u_ready), 0);
        tick();
        // Full pipe with d_ready: accept and emit together.
        applyStimulus(1'b1, 32'h5, 1'b1);
        checkOutput("full_pass_u_ready", DATA_WIDTH'(u_ready), 1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("full_pass_occupancy", DATA_WIDTH'(occupancy), 4);
        checkOutput("full_pass_d_data", d_data, 32'h2);
        drain("stall_drain");

        // Bubble collapse: 0x10 at t0, 0x20 at t3, downstream stalled.
        applyStimulus(1'b1, 32'h10, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h20, 1'b0);
        checkOutput("bubble_accept", DATA_WIDTH'(u_ready), 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("bubble_occupancy", DATA_WIDTH'(occupancy), 2);
        checkOutput("bubble_head_d_data", d_data, 32'h10);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("bubble_first_out", d_data, 32'h10);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("bubble_second_valid", DATA_WIDTH'(d_valid), 1);
        checkOutput("bubble_second_out", d_data, 32'h20);
        drain("bubble_drain");

        // Flush with a beat waiting upstream.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, DATA_WIDTH'(k), 1'b0);
            tick();
        end
        flush = 1'b1;
        applyStimulus(1'b1, 32'h77, 1'b0);
        checkOutput("flush_u_ready", DATA_WIDTH'(u_ready), 0);
        checkOutput("flush_occupancy_before", DATA_WIDTH'(occupancy), 3);
        tick();
        flush = 1'b0;
        applyStimulus(1'b1, 32'h77, 1'b0);
        checkOutput("flush_occupancy_after", DATA_WIDTH'(occupancy), 0);
        checkOutput("flush_d_valid_after", DATA_WIDTH'(d_valid), 0);
        checkOutput("flush_held_beat_accept", DATA_WIDTH'(u_ready), 1);
        tick();
        drain("flush_drain");

        // Reset in the middle of random traffic.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            tick();
        end
        rst_n = 1'b0;
        applyStimulus(1'b1, $urandom, 1'b1);
        checkOutput("midreset_u_ready_1", DATA_WIDTH'(u_ready), 0);
        tick();
        checkOutput("midreset_u_ready_2", DATA_WIDTH'(u_ready), 0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("midreset_d_valid", DATA_WIDTH'(d_valid), 0);
        checkOutput("midreset_d_data", d_data, 0);
        checkOutput("midreset_occupancy", DATA_WIDTH'(occupancy), 0);
        applyStimulus(1'b1, 32'hBEEF, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        lat = 1;
        while (d_valid !== 1'b1 && lat < 20) begin
            tick();
            applyStimulus(1'b0, '0, 1'b1);
            lat++;
        end
        checkOutput("midreset_first_latency", DATA_WIDTH'(lat), STAGES);
        checkOutput("midreset_first_data", d_data, 32'hBEEF);
        drain("midreset_drain");

        // Random valid/ready soak; the monitor does the checking.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0));
            tick();
        end
        drain("soak_drain");
        tick();
        checkOutput("scoreboard_empty", DATA_WIDTH'(expQ.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
